hp_bar_animator: RTL and testbench

- Draws an animated, colour-graded bar sprite (e.g. a battle HP bar) at (x_in, y_in) in the video pixel pipeline.
- The filled portion slides toward a commanded target width at a fixed rate per video frame, so damage or heal ticks down or up visibly instead of jumping.
- Output is a registered 12-bit RGB pixel, ORed into the scene mixer alongside the other sprite blocks.

---
 rtl/hp_bar_animator.sv | 194 +++++++++++++++++++
 tb/tb_hp_bar_animator.sv | 356 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hp_bar_animator.sv
// hp_bar_animator: animated, colour-graded bar sprite (e.g. an HP bar).
// The fill slides toward a commanded target by STEP px every FRAME_DIV frames.
module hp_bar_animator #(
    parameter int          WIDTH     = 64,
    parameter int          HEIGHT    = 8,
    parameter int          STEP      = 1,
    parameter int          FRAME_DIV = 2,
    parameter logic [11:0] COLOR_HI  = 12'h0F0,
    parameter logic [11:0] COLOR_MID = 12'hFF0,
    parameter logic [11:0] COLOR_LO  = 12'hF00,
    parameter logic [11:0] BG_COLOR  = 12'h444,
    localparam int         FW        = $clog2(WIDTH + 1)
) (
    input  logic          clk_in,
    input  logic          rst_n_in,
    input  logic          frame_in,
    input  logic [10:0]   x_in,
    input  logic [9:0]    y_in,
    input  logic [10:0]   hcount_in,
    input  logic [9:0]    vcount_in,
    input  logic [FW-1:0] target_in,
    input  logic          target_valid_in,
    input  logic          snap_in,
    output logic [11:0]   pixel_out,
    output logic          busy_out,
    output logic          done_out
);

    localparam int CW = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
    localparam int MW = FW + 3;

    localparam logic [FW-1:0] WIDTH_F  = FW'(WIDTH);
    localparam logic [FW-1:0] STEP_F   = FW'(STEP);
    localparam logic [CW-1:0] CNT_LAST = CW'(FRAME_DIV - 1);
    localparam logic [MW-1:0] WIDTH_M  = MW'(WIDTH);
    localparam logic [MW-1:0] FIVE_M   = MW'(5);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHRINK = 2'd1,
        GROW   = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [FW-1:0] fill_q, fill_d;
    logic [FW-1:0] target_q, target_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          done_q, done_d;
    logic [11:0]   pixel_q, pixel_d;

    logic [FW-1:0] tgt_clamp;
    logic [FW-1:0] diff;
    logic [FW-1:0] amt;
    logic          fill_gt;
    logic          fill_lt;
    logic          land;
    logic          strobe;
    logic          running;
    logic          step_en;

    // Clamp the incoming target so the fill can never exceed the box.
    assign tgt_clamp = (target_in > WIDTH_F) ? WIDTH_F : target_in;

    assign fill_gt = fill_q > target_q;
    assign fill_lt = fill_q < target_q;
    assign diff    = fill_gt ? (fill_q - target_q) : (target_q - fill_q);
    assign amt     = (diff < STEP_F) ? diff : STEP_F;
    assign land    = diff <= STEP_F;

    // A strobe in the same cycle as frame_in swallows that frame.
    assign strobe  = snap_in | target_valid_in;

    // Only count frames once the state agrees with the required direction.
    assign running = ((state_q == SHRINK) && fill_gt) ||
                     ((state_q == GROW)   && fill_lt);

    assign step_en = frame_in && !strobe && running && (cnt_q == CNT_LAST);

    // Animation state, fill, target, frame divider and done pulse.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q  <= IDLE;
            fill_q   <= WIDTH_F;
            target_q <= WIDTH_F;
            cnt_q    <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            fill_q   <= fill_d;
            target_q <= target_d;
            cnt_q    <= cnt_d;
            done_q   <= done_d;
        end
    end

    // Next state: strobes freeze or reset direction, otherwise follow the gap.
    always_comb begin
        state_d = state_q;
        if (snap_in) begin
            state_d = IDLE;
        end else if (target_valid_in) begin
            state_d = state_q;
        end else if (step_en && land) begin
            state_d = IDLE;
        end else if (fill_gt) begin
            state_d = SHRINK;
        end else if (fill_lt) begin
            state_d = GROW;
        end else begin
            state_d = IDLE;
        end
    end

    // Datapath updates: capture, snap, frame divider and clamped step.
    always_comb begin
        fill_d   = fill_q;
        target_d = target_q;
        cnt_d    = cnt_q;
        done_d   = 1'b0;
        if (target_valid_in) begin
            target_d = tgt_clamp;
            cnt_d    = '0;
        end
        if (snap_in) begin
            fill_d = target_valid_in ? tgt_clamp : target_q;
            cnt_d  = '0;
        end else if (frame_in && !target_valid_in && running) begin
            if (cnt_q == CNT_LAST) begin
                cnt_d  = '0;
                fill_d = fill_gt ? (fill_q - amt) : (fill_q + amt);
                done_d = land;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    logic [11:0]   h_ext;
    logic [11:0]   h_end;
    logic [11:0]   f_end;
    logic [10:0]   v_ext;
    logic [10:0]   v_end;
    logic          in_box;
    logic          in_fill;
    logic [MW-1:0] fill_m;
    logic [11:0]   fill_col;

    // One extra bit on each axis keeps the box edges from wrapping.
    assign h_ext = {1'b0, hcount_in};
    assign h_end = {1'b0, x_in} + 12'(WIDTH);
    assign f_end = {1'b0, x_in} + 12'(fill_q);
    assign v_ext = {1'b0, vcount_in};
    assign v_end = {1'b0, y_in} + 11'(HEIGHT);

    assign in_box = (hcount_in >= x_in) && (h_ext < h_end) &&
                    (vcount_in >= y_in) && (v_ext < v_end);
    assign in_fill = in_box && (h_ext < f_end);

    assign fill_m = MW'(fill_q);

    // Colour grade from the current fill fraction: >=1/2, >=1/5, else low.
    always_comb begin
        fill_col = COLOR_LO;
        if ((fill_m << 1) >= WIDTH_M) begin
            fill_col = COLOR_HI;
        end else if ((fill_m * FIVE_M) >= WIDTH_M) begin
            fill_col = COLOR_MID;
        end
    end

    // Pixel select: fill colour, empty-box background, or transparent.
    always_comb begin
        pixel_d = 12'h000;
        if (in_fill) begin
            pixel_d = fill_col;
        end else if (in_box) begin
            pixel_d = BG_COLOR;
        end
    end

    // Registered pixel output for the scene mixer.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            pixel_q <= 12'h000;
        end else begin
            pixel_q <= pixel_d;
        end
    end

    assign pixel_out = pixel_q;
    assign busy_out  = (state_q != IDLE);
    assign done_out  = done_q;

endmodule

// File: tb/tb_hp_bar_animator.sv
// tb_hp_bar_animator: directed tables and sequences plus random slots
// checked against a frame-level behavioural model of the bar.
module tb_hp_bar_animator;

    localparam int W  = 64;
    localparam int H  = 8;
    localparam int ST = 1;
    localparam int FD = 2;
    localparam int FW = $clog2(W + 1);
    localparam int X0 = 100;
    localparam int Y0 = 50;

    logic          clk_in = 1'b0;
    logic          rst_n_in;
    logic          frame_in;
    logic [10:0]   x_in;
    logic [9:0]    y_in;
    logic [10:0]   hcount_in;
    logic [9:0]    vcount_in;
    logic [FW-1:0] target_in;
    logic          target_valid_in;
    logic          snap_in;
    logic [11:0]   pixel_out;
    logic          busy_out;
    logic          done_out;

    int n_cmp = 0;
    int n_bad = 0;

    int cx = X0;
    int cy = Y0;
    int m_fill;
    int m_target;
    int m_cnt;

    hp_bar_animator dut (
        .clk_in          (clk_in),
        .rst_n_in        (rst_n_in),
        .frame_in        (frame_in),
        .x_in            (x_in),
        .y_in            (y_in),
        .hcount_in       (hcount_in),
        .vcount_in       (vcount_in),
        .target_in       (target_in),
        .target_valid_in (target_valid_in),
        .snap_in         (snap_in),
        .pixel_out       (pixel_out),
        .busy_out        (busy_out),
        .done_out        (done_out)
    );

    always #5 clk_in = ~clk_in;

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        int          h;
        int          v;
        logic [11:0] px;
    } vec_t;

    vec_t tbl[9];

    function automatic logic [11:0] colour_of(input int f);
        if (f * 2 >= W) return 12'h0F0;
        if (f * 5 >= W) return 12'hFF0;
        return 12'hF00;
    endfunction

    function automatic logic [11:0] exp_pix(input int h, input int v,
                                            input int x, input int y,
                                            input int f);
        if (h < x || h >= x + W || v < y || v >= y + H) return 12'h000;
        if (h < x + f) return colour_of(f);
        return 12'h444;
    endfunction

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic probe(input int h, input int v, output logic [11:0] p);
        hcount_in = 11'(h);
        vcount_in = 10'(v);
        tick();
        p = pixel_out;
    endtask

    task automatic check_fill(input string nm, input int f);
        logic [11:0] p;
        if (f > 0) begin
            probe(cx + f - 1, cy, p);
            chk({nm, "_last"}, p, exp_pix(cx + f - 1, cy, cx, cy, f));
        end
        probe(cx + f, cy + H - 1, p);
        chk({nm, "_next"}, p, exp_pix(cx + f, cy + H - 1, cx, cy, f));
    endtask

    task automatic pulse(input bit fr, input bit tv, input int tg,
                         input bit sn, output logic d, output logic b);
        frame_in        = fr;
        target_valid_in = tv;
        target_in       = FW'(tg);
        snap_in         = sn;
        tick();
        d = done_out;
        b = busy_out;
        frame_in        = 1'b0;
        target_valid_in = 1'b0;
        snap_in         = 1'b0;
    endtask

    task automatic frame_chk(input string nm, input logic exp_d);
        logic d;
        logic b;
        pulse(1'b1, 1'b0, 0, 1'b0, d, b);
        chk(nm, d, exp_d);
        tick();
        tick();
    endtask

    initial begin
        logic [11:0] p;
        logic        d;
        logic        b;
        int          f;
        int          ndone;

        rst_n_in        = 1'b0;
        frame_in        = 1'b0;
        target_valid_in = 1'b0;
        snap_in         = 1'b0;
        target_in       = '0;
        x_in            = 11'(X0);
        y_in            = 10'(Y0);
        hcount_in       = 11'(X0);
        vcount_in       = 10'(Y0);

        tbl[0] = '{100, 50, 12'h0F0};
        tbl[1] = '{163, 50, 12'h0F0};
        tbl[2] = '{100, 57, 12'h0F0};
        tbl[3] = '{163, 57, 12'h0F0};
        tbl[4] = '{130, 53, 12'h0F0};
        tbl[5] = '{99,  50, 12'h000};
        tbl[6] = '{164, 50, 12'h000};
        tbl[7] = '{130, 58, 12'h000};
        tbl[8] = '{130, 49, 12'h000};

        // reset: outputs held at zero
        tick();
        tick();
        tick();
        chk("rst_pixel", pixel_out, 12'h000);
        chk("rst_busy", busy_out, 1'b0);
        chk("rst_done", done_out, 1'b0);
        #2 rst_n_in = 1'b1;
        tick();

        for (int i = 0; i < 9; i++) begin
            probe(tbl[i].h, tbl[i].v, p);
            chk($sformatf("scan%0d", i), p, tbl[i].px);
        end
        chk("scan_busy", busy_out, 1'b0);

        // shrink to 60
        pulse(1'b0, 1'b1, 60, 1'b0, d, b);
        chk("t60_strobe_done", d, 1'b0);
        tick();
        tick();
        for (int i = 1; i <= 8; i++) begin
            chk("t60_busy_pre", busy_out, 1'b1);
            pulse(1'b1, 1'b0, 0, 1'b0, d, b);
            chk("t60_done", d, i == 8);
            chk("t60_busy", b, i != 8);
            tick();
            tick();
        end
        probe(160, 50, p);
        chk("t60_h160", p, 12'h444);
        probe(159, 50, p);
        chk("t60_h159", p, 12'h0F0);

        // shrink to 10 with colour grading
        pulse(1'b0, 1'b1, 10, 1'b0, d, b);
        tick();
        tick();
        f = 60;
        ndone = 0;
        for (int i = 1; i <= 100; i++) begin
            pulse(1'b1, 1'b0, 0, 1'b0, d, b);
            if (i % 2 == 0) f--;
            chk("t10_done", d, i == 100);
            if (d === 1'b1) ndone++;
            probe(X0, Y0, p);
            chk("t10_colour", p, colour_of(f));
            if (i % 2 == 0 && f == 32) chk("t10_c32", p, 12'h0F0);
            if (i % 2 == 0 && f == 31) chk("t10_c31", p, 12'hFF0);
            if (i % 2 == 0 && f == 13) chk("t10_c13", p, 12'hFF0);
            if (i % 2 == 0 && f == 12) chk("t10_c12", p, 12'hF00);
        end
        chk("t10_ndone", ndone, 1);
        check_fill("t10_fill", 10);

        // retarget with simultaneous frame, reversing direction
        pulse(1'b0, 1'b1, 64, 1'b1, d, b);
        chk("rev_snap_done", d, 1'b0);
        tick();
        check_fill("rev_fill64", 64);
        pulse(1'b0, 1'b1, 0, 1'b0, d, b);
        tick();
        tick();
        for (int i = 0; i < 48; i++) frame_chk("rev_shrink_done", 1'b0);
        check_fill("rev_fill40", 40);
        pulse(1'b1, 1'b1, 50, 1'b0, d, b);
        chk("rev_strobe_done", d, 1'b0);
        tick();
        tick();
        for (int i = 1; i <= 20; i++) begin
            frame_chk("rev_grow_done", i == 20);
            if (i == 19) check_fill("rev_fill49", 49);
        end
        check_fill("rev_fill50", 50);
        chk("rev_busy", busy_out, 1'b0);

        // over-range target clamps; snap to zero
        pulse(1'b0, 1'b1, 64, 1'b1, d, b);
        tick();
        check_fill("clamp_fill64", 64);
        pulse(1'b0, 1'b1, 200, 1'b0, d, b);
        chk("clamp_done0", d, 1'b0);
        tick();
        chk("clamp_busy", busy_out, 1'b0);
        chk("clamp_done1", done_out, 1'b0);
        for (int i = 0; i < 4; i++) frame_chk("clamp_frame_done", 1'b0);
        check_fill("clamp_fill", 64);
        pulse(1'b0, 1'b1, 0, 1'b0, d, b);
        chk("snap_strobe_done", d, 1'b0);
        tick();
        pulse(1'b0, 1'b0, 0, 1'b1, d, b);
        chk("snap_done", d, 1'b0);
        tick();
        chk("snap_done2", done_out, 1'b0);
        frame_chk("snap_frame_done", 1'b0);
        probe(100, 50, p);
        chk("snap_h100", p, 12'h444);
        probe(163, 57, p);
        chk("snap_h163", p, 12'h444);
        probe(164, 50, p);
        chk("snap_h164", p, 12'h000);
        chk("snap_busy", busy_out, 1'b0);

        // asynchronous reset mid-animation
        pulse(1'b0, 1'b1, 64, 1'b0, d, b);
        tick();
        tick();
        for (int i = 0; i < 4; i++) frame_chk("ar_done", 1'b0);
        probe(X0, Y0, p);
        chk("ar_pre_pixel", p, 12'hF00);
        chk("ar_pre_busy", busy_out, 1'b1);
        @(posedge clk_in);
        #3 rst_n_in = 1'b0;
        #1;
        chk("ar_pixel", pixel_out, 12'h000);
        chk("ar_busy", busy_out, 1'b0);
        chk("ar_done", done_out, 1'b0);
        tick();
        tick();
        chk("ar_hold_pixel", pixel_out, 12'h000);
        rst_n_in = 1'b1;
        tick();
        check_fill("ar_fill", 64);
        chk("ar_post_busy", busy_out, 1'b0);

        // random slots against the frame-level model
        m_fill   = W;
        m_target = W;
        m_cnt    = 0;
        for (int s = 0; s < 400; s++) begin
            int  r;
            int  tg;
            int  gap;
            int  mv;
            bit  fr;
            bit  tv;
            bit  sn;
            bit  exp_done;

            cx   = int'($urandom_range(0, 2047));
            cy   = int'($urandom_range(0, 1023));
            x_in = 11'(cx);
            y_in = 10'(cy);
            r    = int'($urandom_range(0, 99));
            tg   = int'($urandom_range(0, 127));
            fr   = 1'b0;
            tv   = 1'b0;
            sn   = 1'b0;
            if (r < 55) fr = 1'b1;
            else if (r < 70) tv = 1'b1;
            else if (r < 78) sn = 1'b1;
            else if (r < 84) begin tv = 1'b1; sn = 1'b1; end
            else if (r < 92) begin tv = 1'b1; fr = 1'b1; end
            else begin sn = 1'b1; fr = 1'b1; end

            exp_done = 1'b0;
            if (tv) begin
                m_target = (tg > W) ? W : tg;
                m_cnt    = 0;
            end
            if (sn) begin
                m_fill = m_target;
                m_cnt  = 0;
            end else if (fr && !tv && m_fill != m_target) begin
                m_cnt++;
                if (m_cnt == FD) begin
                    m_cnt = 0;
                    gap = m_target - m_fill;
                    mv  = (gap < 0) ? -gap : gap;
                    if (mv > ST) mv = ST;
                    m_fill   = (gap < 0) ? m_fill - mv : m_fill + mv;
                    exp_done = (m_fill == m_target);
                end
            end

            pulse(fr, tv, tg, sn, d, b);
            chk("rnd_done", d, exp_done);
            for (int k = 0; k < 3; k++) begin
                int h;
                int v;
                h = (cx + int'($urandom_range(0, 69)) - 3) & 2047;
                v = (cy + int'($urandom_range(0, 11)) - 2) & 1023;
                probe(h, v, p);
                chk("rnd_pixel", p, exp_pix(h, v, cx, cy, m_fill));
                chk("rnd_done_idle", done_out, 1'b0);
            end
            chk("rnd_busy", busy_out, m_fill != m_target);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
